// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg
//   Shared definitions for the memory responder: run-FSM state encoding,
//   run-cycle counter width and host-port memory select codes.
package mem_resp_pkg;

  // Run FSM states. START lasts exactly one cycle and produces the start pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int RUN_CNT_W = 16;

  localparam logic HOST_SEL_IM = 1'b0;
  localparam logic HOST_SEL_DM = 1'b1;

endpackage

// File: rtl/mem_bank.sv
// mem_bank
//   One single-port memory array with a synchronous write and a registered
//   read. Accesses at or beyond DEPTH are guarded: reads return 0, writes are
//   dropped. The read register resets to 0; the array contents do not reset.
// Ports
//   i_clk     clock, posedge
//   i_rst_n   asynchronous active-low reset (read register only)
//   i_rd      read enable; o_rdata updates after the edge, holds otherwise
//   i_wr      write enable; array updated at the edge
//   i_addr    word address
//   i_wdata   write data
//   o_rdata   registered read data
module mem_bank #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rd,
  input  logic                  i_wr,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_inRange;
  logic [IDX_W-1:0]      w_idx;

  // Widen by one bit so the comparison also works when DEPTH == 2**ADDR_WIDTH.
  assign w_inRange = ({1'b0, i_addr} < (ADDR_WIDTH + 1)'(DEPTH));
  assign w_idx     = i_addr[IDX_W-1:0];

  // Array write: no reset, so contents survive a reset of the responder.
  always_ff @(posedge i_clk) begin
    if (i_wr && w_inRange) begin
      r_mem[w_idx] <= i_wdata;
    end
  end

  // Registered read. Non-blocking assignment gives read-before-write when a
  // read and a write hit the same address on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_rd) begin
      r_rdata <= w_inRange ? r_mem[w_idx] : '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Target side of the processor's instruction and data memory interfaces.
//   Owns the IM and DM banks, lets a host preload/read them while the
//   processor is idle, and runs a program via a start/stop handshake with a
//   cycle counter and watchdog.
// Ports
//   clk, rst                       clock and asynchronous active-low reset
//   host_valid/ready/sel/wr/addr   host access request (sel 0=IM, 1=DM)
//   host_wdata, host_rdata         host write data / read data
//   host_rvalid                    host_rdata valid for one cycle
//   host_run                       launch program
//   busy, done, timeout            run status
//   run_cycles                     cycles spent in RUN for last/current run
//   start, stop                    processor handshake
//   im_addr/im_rd/im_r_data        processor instruction fetch port
//   dm_addr/dm_rd/dm_wr/dm_w_data/dm_r_data  processor data port
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int IM_DEPTH   = 256,
  parameter int DM_DEPTH   = 256,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_sel,
  input  logic                  host_wr,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  input  logic                  host_run,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [RUN_CNT_W-1:0]  run_cycles,
  output logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] im_addr,
  input  logic                  im_rd,
  output logic [DATA_WIDTH-1:0] im_r_data,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic                  dm_rd,
  input  logic                  dm_wr,
  input  logic [DATA_WIDTH-1:0] dm_w_data,
  output logic [DATA_WIDTH-1:0] dm_r_data
);

  state_t                r_state;
  state_t                w_nextState;
  logic                  r_active;
  logic [RUN_CNT_W-1:0]  r_runCycles;
  logic                  r_timeout;
  logic                  r_hostRvalid;
  logic                  r_hostSel;
  logic [DATA_WIDTH-1:0] r_hostRdataLast;

  logic                  w_hostAcc;
  logic                  w_hostRd;
  logic                  w_hostWr;
  logic                  w_procOwn;
  logic                  w_wdFire;

  logic                  w_imRd;
  logic                  w_imWr;
  logic [ADDR_WIDTH-1:0] w_imAddr;
  logic [DATA_WIDTH-1:0] w_imRdata;
  logic                  w_dmRd;
  logic                  w_dmWr;
  logic [ADDR_WIDTH-1:0] w_dmAddr;
  logic [DATA_WIDTH-1:0] w_dmWdata;
  logic [DATA_WIDTH-1:0] w_dmRdata;

  // r_active holds host_ready low until the first edge after reset release.
  assign host_ready = r_active && ((r_state == IDLE) || (r_state == DONE));
  assign w_hostAcc  = host_valid && host_ready;
  assign w_hostRd   = w_hostAcc && !host_wr;
  assign w_hostWr   = w_hostAcc && host_wr;
  assign w_procOwn  = (r_state == RUN);
  assign w_wdFire   = (r_runCycles == RUN_CNT_W'(TIMEOUT - 1));

  // FSM state register plus the post-reset ready qualifier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_active <= 1'b1;
    end
  end

  // Next-state logic. In IDLE a simultaneous host access wins and the run
  // request is dropped. Stop and watchdog both end the run.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (r_active && host_run && !host_valid) w_nextState = START;
      START:   w_nextState = RUN;
      RUN:     if (stop || w_wdFire) w_nextState = DONE;
      DONE:    if (host_run) w_nextState = START;
      default: w_nextState = IDLE;
    endcase
  end

  // Run-cycle counter and watchdog flag. Both clear while leaving START; the
  // counter also steps on the edge that ends the run. A stop on the watchdog
  // edge counts as a normal halt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_runCycles <= '0;
      r_timeout   <= 1'b0;
    end else if (r_state == START) begin
      r_runCycles <= '0;
      r_timeout   <= 1'b0;
    end else if (r_state == RUN) begin
      r_runCycles <= r_runCycles + 1'b1;
      if (w_wdFire && !stop) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign busy       = (r_state == START) || (r_state == RUN);
  assign done       = (r_state == DONE);
  assign start      = (r_state == START);
  assign timeout    = r_timeout;
  assign run_cycles = r_runCycles;

  // Owner mux in front of each bank: processor during RUN, host otherwise.
  always_comb begin
    w_imRd    = 1'b0;
    w_imWr    = 1'b0;
    w_imAddr  = host_addr;
    w_dmRd    = 1'b0;
    w_dmWr    = 1'b0;
    w_dmAddr  = host_addr;
    w_dmWdata = host_wdata;
    if (w_procOwn) begin
      w_imRd    = im_rd;
      w_imAddr  = im_addr;
      w_dmRd    = dm_rd;
      w_dmWr    = dm_wr;
      w_dmAddr  = dm_addr;
      w_dmWdata = dm_w_data;
    end else begin
      w_imRd = w_hostRd && (host_sel == HOST_SEL_IM);
      w_imWr = w_hostWr && (host_sel == HOST_SEL_IM);
      w_dmRd = w_hostRd && (host_sel == HOST_SEL_DM);
      w_dmWr = w_hostWr && (host_sel == HOST_SEL_DM);
    end
  end

  mem_bank #(
    .DEPTH      (IM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_imBank (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_rd    (w_imRd),
    .i_wr    (w_imWr),
    .i_addr  (w_imAddr),
    .i_wdata (host_wdata),
    .o_rdata (w_imRdata)
  );

  mem_bank #(
    .DEPTH      (DM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dmBank (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_rd    (w_dmRd),
    .i_wr    (w_dmWr),
    .i_addr  (w_dmAddr),
    .i_wdata (w_dmWdata),
    .o_rdata (w_dmRdata)
  );

  assign im_r_data = w_imRdata;
  assign dm_r_data = w_dmRdata;

  // Host read pipe: remembers which bank answered, and keeps a copy of the
  // returned word so host_rdata holds even if a bank output later changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hostRvalid    <= 1'b0;
      r_hostSel       <= HOST_SEL_IM;
      r_hostRdataLast <= '0;
    end else begin
      r_hostRvalid <= w_hostRd;
      if (w_hostRd) begin
        r_hostSel <= host_sel;
      end
      if (r_hostRvalid) begin
        r_hostRdataLast <= host_rdata;
      end
    end
  end

  assign host_rvalid = r_hostRvalid;
  assign host_rdata  = r_hostRvalid ? ((r_hostSel == HOST_SEL_DM) ? w_dmRdata : w_imRdata)
                                    : r_hostRdataLast;

endmodule
